// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter fed by a no-backpressure byte strobe
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         char_in,
    input  logic               char_valid,
    input  logic               clr_overflow,
    output logic               tx,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]    RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH  = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_next;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]        baud_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 tx_next;
    logic                 pop, push, drop, baud_tick, fifo_nonempty;

    assign baud_tick     = (baud_cnt == '0);
    assign fifo_nonempty = (fifo_count != '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign push = char_valid && ((fifo_count < DEPTH) || pop);
    assign drop = char_valid && !push;

    always_comb begin
        state_next = state;
        tx_next    = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop        = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= char_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            tx_busy <= (state_next != IDLE);

            if (pop) begin
                shift    <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
                bit_idx  <= '0;
                baud_cnt <= RELOAD;
`ifdef UART_TX_PARITY_EN
                parity   <= ^mem[rd_ptr];
`endif
            end else if (state != IDLE) begin
                if (baud_tick) begin
                    baud_cnt <= RELOAD;
                    if (state == DATA) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt - 1'b1;
                end
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;

            // A drop colliding with a clear counts as the first drop after the clear.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_overflow)            drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - bench for uart_tx_fifo against a frame-level queue model
module tb_uart_tx_fifo;
    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    char_in = '0;
    logic          char_valid = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          tx, tx_busy, overflow;
    logic [AW:0]   fifo_count;
    logic [7:0]    drop_cnt;

    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .clr_overflow(clr_overflow), .tx(tx), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;

    logic [7:0] m_q[$];
    int         m_left = 0;
    logic [7:0] m_cur = '0;
    logic       m_ovf = 1'b0;
    int         m_drop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_left = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // Line level implied by position within the current frame.
    function automatic logic exp_tx();
        int slot;
        if (m_left == 0) return 1'b1;
        slot = (FRAME - m_left) / BD;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    task automatic step(input logic v, input logic [7:0] b, input logic c);
        bit do_pop, do_push;
        char_valid   = v;
        char_in      = b;
        clr_overflow = c;
        @(posedge clk);
        do_pop  = (m_q.size() > 0) && (m_left <= 1) && !rst;
        do_push = v && ((m_q.size() < DEPTH) || do_pop) && !rst;
        if (rst) begin
            model_reset();
        end else begin
            if (do_pop) begin
                m_cur  = m_q.pop_front();
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (do_push) m_q.push_back(b);
            if (v && !do_push) begin
                m_ovf  = 1'b1;
                m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (c) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
        #1;
        chk("tx", tx, exp_tx());
        chk("tx_busy", tx_busy, (m_left > 0));
        chk("fifo_count", fifo_count, m_q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        if (tx_busy === 1'b1) busy_cycles++;
        char_valid   = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bit found;

        #12;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;

        idle(9);
        step(1'b1, 8'h55, 1'b0);
        idle(FRAME + 10);

        busy_cycles = 0;
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h43, 1'b0);
        idle(3 * FRAME + 10);
        chk("b2b_busy_cycles", busy_cycles, 3 * FRAME);

        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
        chk("burst_ovf", overflow, 1'b1);
        chk("burst_drop", drop_cnt, 3);
        chk("burst_count", fifo_count, DEPTH);
        step(1'b1, 8'hEE, 1'b1);
        chk("collide_ovf", overflow, 1'b1);
        chk("collide_drop", drop_cnt, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_drop", drop_cnt, 0);
        idle(6 * FRAME);

`ifdef UART_TX_PARITY_EN
        step(1'b1, 8'h07, 1'b0);
        idle(FRAME + 4);
        step(1'b1, 8'h03, 1'b0);
        idle(FRAME + 4);
`endif

        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            if (m_left > 0 && (FRAME - m_left) / BD == 4) found = 1'b1;
            else step(1'b0, 8'h00, 1'b0);
        end
        chk("locate_bit3", found, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_busy", tx_busy, 1'b0);
        chk("async_rst_count", fifo_count, 0);
        model_reset();
        idle(3);
        #2 rst = 1'b0;
        busy_cycles = 0;
        idle(2 * FRAME);
        chk("post_rst_quiet", busy_cycles, 0);

        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end
        idle((DEPTH + 2) * FRAME);
        chk("drained_count", fifo_count, 0);
        chk("drained_busy", tx_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
